// File: rtl/sha_1_pad_pkg.sv
// SHA-1 padder shared constants, state encoding and last-word helper.
// Imported by the padder top level.
package sha_1_pad_pkg;

  localparam int LEN_W = 64;
  localparam int BLK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_SEND,
    S_WAIT,
    S_LENBLK
  } state_t;

  // keep the first n bytes, put the pad marker at byte n, zero the rest
  function automatic logic [31:0] pad_word(
    input logic [31:0] d,
    input logic [2:0]  n
  );
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < n)
        w[31-8*b -: 8] = d[31-8*b -: 8];
      else if (3'(b) == n)
        w[31-8*b -: 8] = PAD_BYTE;
    end
    return w;
  endfunction

endpackage

// File: rtl/sha_1_pad.sv
// SHA-1 message padder: packs a 32-bit word stream into padded
// 512-bit blocks and hands them to the core one at a time.
module sha_1_pad
  import sha_1_pad_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  In_Data,
  input  logic         In_Valid,
  input  logic         In_Last,
  input  logic [2:0]   In_Bytes,
  output logic         In_Ready,
  output logic [511:0] Data,
  output logic [63:0]  Index,
  output logic         Enable,
  input  logic         Ready,
  output logic         Done
);

  state_t state_q, state_d;
  logic [4:0] wcnt_q, wcnt_d;
  logic [BLK_WORDS-1:0][31:0] buf_q, buf_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [63:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic fin_q, fin_d;
  logic lenblk_q, lenblk_d;
  logic rdy_q, rdy_d;
  logic en_q, en_d;
  logic [511:0] data_q, data_d;

  logic accept;
  logic [2:0] nb;
  logic [4:0] slot;
  logic pend;

  assign accept = In_Valid & rdy_q;
  assign nb = (In_Bytes > 3'd4) ? 3'd4 : In_Bytes;

  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    buf_d = buf_q;
    len_d = len_q;
    idx_d = idx_q;
    pend_d = pend_q;
    fin_d = fin_q;
    lenblk_d = lenblk_q;
    en_d = 1'b0;
    data_d = data_q;
    slot = wcnt_q;
    pend = pend_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          wcnt_d = wcnt_q + 5'd1;
          if (In_Last) begin
            buf_d[wcnt_q[3:0]] = pad_word(In_Data, nb);
            len_d = len_q + {58'b0, nb, 3'b000};
            pend_d = (nb == 3'd4);
            state_d = S_PAD;
          end else begin
            buf_d[wcnt_q[3:0]] = In_Data;
            len_d = len_q + 64'd32;
            if (wcnt_q == 5'(BLK_WORDS - 1)) begin
              fin_d = 1'b0;
              lenblk_d = 1'b0;
              state_d = S_SEND;
            end
          end
        end
      end
      S_PAD: begin
        if (pend && slot < 5'(BLK_WORDS)) begin
          buf_d[slot[3:0]] = {PAD_BYTE, 24'h0};
          slot = slot + 5'd1;
          pend = 1'b0;
        end
        pend_d = pend;
        wcnt_d = slot;
        if (slot <= 5'd14 && !pend) begin
          buf_d[14] = len_q[63:32];
          buf_d[15] = len_q[31:0];
          fin_d = 1'b1;
          lenblk_d = 1'b0;
        end else begin
          fin_d = 1'b0;
          lenblk_d = 1'b1;
        end
        state_d = S_SEND;
      end
      S_SEND: begin
        en_d = 1'b1;
        data_d = buf_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Ready) begin
          idx_d = idx_q + 64'd1;
          wcnt_d = '0;
          buf_d = '0;
          if (fin_q) begin
            len_d = '0;
            idx_d = '0;
            fin_d = 1'b0;
            state_d = S_FILL;
          end else if (lenblk_q) begin
            lenblk_d = 1'b0;
            state_d = S_LENBLK;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_LENBLK: begin
        buf_d = '0;
        if (pend_q) buf_d[0] = {PAD_BYTE, 24'h0};
        pend_d = 1'b0;
        buf_d[14] = len_q[63:32];
        buf_d[15] = len_q[31:0];
        fin_d = 1'b1;
        state_d = S_SEND;
      end
      default: state_d = S_FILL;
    endcase
    rdy_d = (state_d == S_FILL) && (wcnt_d < 5'(BLK_WORDS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FILL;
      wcnt_q <= '0;
      buf_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      fin_q <= 1'b0;
      lenblk_q <= 1'b0;
      rdy_q <= 1'b0;
      en_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      buf_q <= buf_d;
      len_q <= len_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      fin_q <= fin_d;
      lenblk_q <= lenblk_d;
      rdy_q <= rdy_d;
      en_q <= en_d;
      data_q <= data_d;
    end
  end

  assign In_Ready = rdy_q;
  assign Enable = en_q;
  assign Data = data_q;
  assign Index = idx_q;
  assign Done = (state_q == S_WAIT) & fin_q & Ready;

endmodule
